cache_line_fill: RTL and testbench
==================================

Name: cache_line_fill

Overview:
Miss-service engine directly downstream of the direct-mapped cache. On a miss, it optionally writes back the dirty victim line, then refills the missing line from a word-wide memory bus. Refill is critical-word-first with wrap-around. Each returned word is written into the cache data array, and completion is signalled with a one-cycle pulse.

Parameters:
ADDR_W, 32, byte address width.
LINE_WORDS, 4, 32-bit words per cache line; power of 2, ≥2. OFS_W = log2(LINE_WORDS).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_req  in  1  cache requests line service; level, held until miss_done
miss_addr  in  ADDR_W  byte address of missing access
victim_dirty  in  1  victim line dirty; sampled with miss_req
victim_addr  in  ADDR_W  byte address within victim line
victim_widx  out  OFS_W  word index into victim line for array read
victim_rdata  in  32  victim word at victim_widx; combinational, same cycle
fill_we  out  1  write strobe into cache data array
fill_widx  out  OFS_W  word index of fill write
fill_wdata  out  32  fill data
miss_done  out  1  one-cycle pulse; line complete in array
busy  out  1  high in any state other than IDLE
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word-aligned byte address
mem_wdata  out  32  write data
mem_gnt  in  1  request accepted at this rising edge
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; cnt=0; all outputs 0. Reset is asynchronous and may occur mid-operation. A partial line is never flagged done, and the cache must reissue the miss.
- Line base address: addr with low OFS_W+2 bits cleared. crit = miss_addr[OFS_W+1:2].
- IDLE → on miss_req=1: latch miss_addr, victim_addr, and victim_dirty; set cnt=0. Next state is WB if dirty, else RD_REQ.
- WB (write-back):
  - Outputs: mem_req=1, mem_we=1, victim_widx=cnt, mem_addr=victim_base+cnt*4, mem_wdata=victim_rdata.
  - On mem_gnt: cnt++. When cnt==LINE_WORDS-1 is granted: cnt=0, go to RD_REQ.
  - Write-back order is ascending 0..N-1; no wrap.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=miss_base+((crit+cnt) mod LINE_WORDS)*4. On mem_gnt → RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid:
  - fill_we=1, fill_widx=(crit+cnt) mod N, fill_wdata=mem_rdata.
  - cnt++. Last word → DONE, else → RD_REQ.
- DONE: miss_done=1 for exactly one cycle → IDLE.
- Memory rules:
  - mem_addr, mem_we, and mem_wdata stay stable while mem_req=1 and no grant has occurred.
  - At most one read is outstanding.
  - mem_rvalid may arrive no earlier than the cycle after mem_gnt.
  - mem_rvalid outside RD_WAIT is ignored.
- Cache rules:
  - miss_req is ignored outside IDLE.
  - The cache drops miss_req in the cycle after miss_done. If miss_req is still high in IDLE, it is accepted as a new miss.
- Index arithmetic is mod LINE_WORDS (wraps); the counter is OFS_W+1 bits wide.
- Latency (zero-wait grant, rvalid one cycle after grant), with miss accepted at cycle 0:
  - Clean miss: miss_done at cycle 2N+1.
  - Dirty miss: adds N cycles.

Test Plan:
1. Clean miss, miss_addr=0x1000, N=4, immediate gnt, rvalid +1 → reads at 0x1000, 0x1004, 0x1008, 0x100C; fill_widx 0,1,2,3; miss_done at cycle 9; busy high cycles 1–9.
2. Critical word wrap, miss_addr=0x200C → read addresses 0x200C, 0x2000, 0x2004, 0x2008; fill_widx 3,0,1,2; data written matches mem_rdata per index.
3. Dirty miss, victim_addr=0x4004, miss_addr=0x8000 → four writes to 0x4000–0x400C carrying victim_rdata for widx 0–3, then four reads from 0x8000; miss_done at cycle 13.
4. Backpressure: mem_gnt held low 5 cycles in RD_REQ and WB → mem_req, mem_addr, mem_we, and mem_wdata all held stable; no cnt advance; completion delayed by exactly the stall cycles.
5. Spurious inputs: mem_rvalid pulsed in RD_REQ and IDLE, miss_req toggled while busy → no fill_we and no state change.
6. Reset asserted during RD_WAIT after 2 fills → all outputs 0 immediately, no miss_done. A new miss after reset restarts from word crit with cnt=0.

Source files
------------

// File: rtl/cache_line_fill.sv
// Miss-service engine: optional dirty-victim write-back, then critical-word-first
// line refill from a word-wide memory bus, one word per request/response pair.
module cache_line_fill #(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_WORDS = 4,
    localparam int OFS_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic [OFS_W-1:0]  victim_widx,
    input  logic [31:0]       victim_rdata,
    output logic              fill_we,
    output logic [OFS_W-1:0]  fill_widx,
    output logic [31:0]       fill_wdata,
    output logic              miss_done,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int              TAG_W = ADDR_W - OFS_W - 2;
    localparam logic [OFS_W:0]  LAST  = (OFS_W + 1)'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [OFS_W:0]   cnt, cnt_nxt;
    logic [TAG_W-1:0] miss_tag, victim_tag;
    logic [OFS_W-1:0] crit, rd_idx, wb_idx;
    logic             accept;

    // Only line-base and word-offset bits matter; byte offsets are dropped.
    logic unused_bits;
    assign unused_bits = ^{miss_addr[1:0], victim_addr[OFS_W+1:0]};

    assign wb_idx = cnt[OFS_W-1:0];
    assign rd_idx = crit + cnt[OFS_W-1:0];  // wraps mod LINE_WORDS by width

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_tag   <= '0;
            victim_tag <= '0;
            crit       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                miss_tag   <= miss_addr[ADDR_W-1:OFS_W+2];
                victim_tag <= victim_addr[ADDR_W-1:OFS_W+2];
                crit       <= miss_addr[OFS_W+1:2];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept      = 1'b0;
        victim_widx = '0;
        fill_we     = 1'b0;
        fill_widx   = '0;
        fill_wdata  = '0;
        miss_done   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (miss_req) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = victim_dirty ? WB : RD_REQ;
                end
            end
            WB: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                victim_widx = wb_idx;
                mem_addr    = {victim_tag, wb_idx, 2'b00};
                mem_wdata   = victim_rdata;
                if (mem_gnt) begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = RD_REQ;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, rd_idx, 2'b00};
                if (mem_gnt) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Response data goes straight into the array; nothing is buffered.
                if (mem_rvalid) begin
                    fill_we    = 1'b1;
                    fill_widx  = rd_idx;
                    fill_wdata = mem_rdata;
                    cnt_nxt    = cnt + 1'b1;
                    state_nxt  = (cnt == LAST) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                miss_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: table of miss scenarios with hand-computed
// address/index/latency expectations, plus idle-time spurious-input checks.
module tb_cache_line_fill;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [1:0]  victim_widx;
    logic [31:0] victim_rdata;
    logic        fill_we;
    logic [1:0]  fill_widx;
    logic [31:0] fill_wdata;
    logic        miss_done;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Victim array model: each word carries its own index.
    assign victim_rdata = 32'hA5A5_0000 | {30'b0, victim_widx};

    cache_line_fill #(.ADDR_W(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_widx(victim_widx), .victim_rdata(victim_rdata),
        .fill_we(fill_we), .fill_widx(fill_widx), .fill_wdata(fill_wdata),
        .miss_done(miss_done), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0]           maddr;
        logic [31:0]           vaddr;
        logic                  dirty;
        int                    swb;    // grant-stall cycles on first write-back word
        int                    srd;    // grant-stall cycles on first read
        logic                  spur;   // spurious rvalid / miss_req toggling while busy
        int                    abort;  // cycle to assert reset (0 = never)
        int                    done;   // expected miss_done cycle
        logic [0:3][31:0]      wr;
        logic [0:3][31:0]      rd;
        logic [0:3][1:0]       widx;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {busy, miss_done, fill_we, mem_req, mem_we, victim_widx, fill_widx,
                mem_addr ^ mem_wdata ^ fill_wdata};
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int wr_n = 0, rd_n = 0, fl_n = 0;
        int swb = v.swb, srd = v.srd;
        logic pend = 1'b0, pstall = 1'b0;
        logic [31:0] pa = '0, pd = '0;
        logic pw = 1'b0;
        string tg;
        @(negedge clk);
        miss_addr = v.maddr; victim_addr = v.vaddr; victim_dirty = v.dirty;
        miss_req = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int cyc = 1; cyc <= v.done + 1; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            tg = $sformatf("v%0d c%0d", id, cyc);
            mem_gnt = 1'b0;
            if (cyc == v.abort) begin
                rst_n = 1'b0; mem_rvalid = 1'b0; miss_req = 1'b0;
                #1;
                chk({tg, " reset_outs"}, outs_vec(), 64'd0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk({tg, " reset_hold"}, {62'd0, busy, miss_done}, 64'd0);
                end
                rst_n = 1'b1;
                return;
            end
            mem_rvalid = pend || v.spur;
            mem_rdata  = pend ? 32'hD000_0000 + 32'(fl_n) : 32'hBAD0_BAD0;
            if (v.spur && cyc >= 2 && cyc < v.done) begin
                miss_req = cyc[0]; miss_addr = 32'hFFFF_FFFC; victim_dirty = 1'b1;
            end
            #1;
            chk({tg, " busy"}, {63'd0, busy}, {63'd0, cyc <= v.done});
            chk({tg, " miss_done"}, {63'd0, miss_done}, {63'd0, cyc == v.done});
            if (pend) begin
                chk({tg, " fill_we"}, {63'd0, fill_we}, 64'd1);
                chk({tg, " fill_widx"}, {62'd0, fill_widx}, {62'd0, v.widx[fl_n]});
                chk({tg, " fill_wdata"}, {32'd0, fill_wdata}, {32'd0, 32'hD000_0000 + 32'(fl_n)});
                fl_n++;
                pend = 1'b0;
            end else begin
                chk({tg, " no_fill"}, {63'd0, fill_we}, 64'd0);
            end
            if (mem_req) begin
                if (pstall)
                    chk({tg, " stall_hold"}, {31'd0, mem_we, mem_addr, mem_wdata},
                        {31'd0, pw, pa, pd});
                if (mem_we) begin
                    if (wr_n < 4) begin
                        chk({tg, " wb_addr"}, {32'd0, mem_addr}, {32'd0, v.wr[wr_n]});
                        chk({tg, " wb_data"}, {32'd0, mem_wdata}, {32'd0, 32'hA5A5_0000 + 32'(wr_n)});
                    end else chk({tg, " extra_wb"}, 64'd1, 64'd0);
                end else begin
                    if (rd_n < 4) chk({tg, " rd_addr"}, {32'd0, mem_addr}, {32'd0, v.rd[rd_n]});
                    else chk({tg, " extra_rd"}, 64'd1, 64'd0);
                end
                if (mem_we ? (wr_n == 0 && swb > 0) : (rd_n == 0 && srd > 0)) begin
                    if (mem_we) swb--; else srd--;
                    pstall = 1'b1; pa = mem_addr; pw = mem_we; pd = mem_wdata;
                end else begin
                    pstall = 1'b0;
                    mem_gnt = 1'b1;
                    if (mem_we) wr_n++;
                    else begin rd_n++; pend = 1'b1; end
                end
            end else begin
                if (pstall) chk({tg, " req_dropped"}, 64'd0, 64'd1);
                pstall = 1'b0;
            end
            if (cyc >= v.done) miss_req = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk($sformatf("v%0d n_wb", id), 64'(wr_n), v.dirty ? 64'd4 : 64'd0);
        chk($sformatf("v%0d n_rd", id), 64'(rd_n), 64'd4);
        chk($sformatf("v%0d n_fill", id), 64'(fl_n), 64'd4);
    endtask

    initial begin
        vecs[0] = '{32'h1000, 32'h0, 1'b0, 0, 0, 1'b0, 0, 9, '0,
                    {32'h1000, 32'h1004, 32'h1008, 32'h100C}, {2'd0, 2'd1, 2'd2, 2'd3}};
        vecs[1] = '{32'h200C, 32'h0, 1'b0, 0, 0, 1'b0, 0, 9, '0,
                    {32'h200C, 32'h2000, 32'h2004, 32'h2008}, {2'd3, 2'd0, 2'd1, 2'd2}};
        vecs[2] = '{32'h8000, 32'h4004, 1'b1, 0, 0, 1'b0, 0, 13,
                    {32'h4000, 32'h4004, 32'h4008, 32'h400C},
                    {32'h8000, 32'h8004, 32'h8008, 32'h800C}, {2'd0, 2'd1, 2'd2, 2'd3}};
        vecs[3] = '{32'h6004, 32'h501C, 1'b1, 5, 5, 1'b0, 0, 23,
                    {32'h5010, 32'h5014, 32'h5018, 32'h501C},
                    {32'h6004, 32'h6008, 32'h600C, 32'h6000}, {2'd1, 2'd2, 2'd3, 2'd0}};
        vecs[4] = '{32'h7008, 32'h0, 1'b0, 0, 0, 1'b1, 0, 9, '0,
                    {32'h7008, 32'h700C, 32'h7000, 32'h7004}, {2'd2, 2'd3, 2'd0, 2'd1}};
        vecs[5] = '{32'h3008, 32'h0, 1'b0, 0, 0, 1'b0, 6, 9, '0,
                    {32'h3008, 32'h300C, 32'h3000, 32'h3004}, {2'd2, 2'd3, 2'd0, 2'd1}};
        vecs[6] = '{32'h3008, 32'h0, 1'b0, 0, 0, 1'b0, 0, 9, '0,
                    {32'h3008, 32'h300C, 32'h3000, 32'h3004}, {2'd2, 2'd3, 2'd0, 2'd1}};

        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", outs_vec(), 64'd0);
        rst_n = 1'b1;

        // Stray responses and grants in IDLE must not write the array or start work.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_0000 + 32'(k);
            #1;
            chk($sformatf("idle_spur%0d", k), {62'd0, fill_we, busy}, 64'd0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        #1;
        chk("idle_stays", {62'd0, busy, mem_req}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
